// File: rtl/dma_rd_resp_router_pkg.sv
// rtl/dma_rd_resp_router_pkg.sv - shared DMA channel types and constants
package dma_rd_resp_router_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_idx_t;

  localparam ch_idx_t CH_A = 2'd0;
  localparam ch_idx_t CH_B = 2'd1;
  localparam ch_idx_t CH_C = 2'd2;
  localparam ch_idx_t CH_D = 2'd3;

  function automatic logic [NUM_CH-1:0] ch_onehot(input ch_idx_t ch);
    ch_onehot = '0;
    ch_onehot[ch] = 1'b1;
  endfunction

endpackage

// File: rtl/dma_rd_resp_router_if.sv
// rtl/dma_rd_resp_router_if.sv - tag push, shared R channel and per-channel read-data bundle
interface dma_rd_resp_router_if #(
  parameter int DW = 32
) ();
  import dma_rd_resp_router_pkg::*;

  logic              push_valid;
  ch_idx_t           push_ch;
  logic              push_ready;

  logic              s_rvalid;
  logic              s_rready;
  logic [DW-1:0]     s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rlast;

  logic [NUM_CH-1:0] m_rvalid;
  logic [NUM_CH-1:0] m_rready;
  logic [DW-1:0]     m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast;

  modport master (
    output push_valid, push_ch, s_rvalid, s_rdata, s_rresp, s_rlast, m_rready,
    input  push_ready, s_rready, m_rvalid, m_rdata, m_rresp, m_rlast
  );

  modport slave (
    input  push_valid, push_ch, s_rvalid, s_rdata, s_rresp, s_rlast, m_rready,
    output push_ready, s_rready, m_rvalid, m_rdata, m_rresp, m_rlast
  );

endinterface

// File: rtl/dma_tag_fifo.sv
// rtl/dma_tag_fifo.sv - in-order tag FIFO with wrap-bit pointers
module dma_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_en;
  logic         rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once the pointers say they are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/dma_rd_resp_router.sv
// rtl/dma_rd_resp_router.sv - steers AXI R beats to the channel that owns the oldest outstanding burst
module dma_rd_resp_router
  import dma_rd_resp_router_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dma_rd_resp_router_if.slave    bus,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   err_orphan
);

  logic              full;
  logic              empty;
  ch_idx_t           head;
  logic              push;
  logic              pop;
  logic              accept;
  logic              orphan;
  logic              drain;
  logic              ov;
  logic              ovd;

  logic [NUM_CH-1:0] vld_q;
  ch_idx_t           och_q;
  logic [DW-1:0]     data_q;
  logic [1:0]        resp_q;
  logic              last_q;
  logic              err_q;

  assign push = bus.push_valid && !full;
  assign pop  = accept && bus.s_rlast;

  dma_tag_fifo #(
    .W     (2),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (bus.push_ch),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (outstanding)
  );

  assign ov     = |vld_q;
  assign drain  = ov && bus.m_rready[och_q];
  assign ovd    = !ov || bus.m_rready[och_q];
  assign accept = bus.s_rvalid && !empty && ovd;
  // A beat with no owner is swallowed, unless a tag is landing this cycle and can claim it next cycle.
  assign orphan = bus.s_rvalid && empty && !bus.push_valid;

  always_comb begin
    bus.s_rready = 1'b0;
    if (empty) bus.s_rready = orphan;
    else       bus.s_rready = ovd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      och_q  <= CH_A;
      data_q <= '0;
      resp_q <= '0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        vld_q  <= ch_onehot(head);
        och_q  <= head;
        data_q <= bus.s_rdata;
        resp_q <= bus.s_rresp;
        last_q <= bus.s_rlast;
      end else if (drain) begin
        vld_q  <= '0;
      end
      if (orphan) err_q <= 1'b1;
    end
  end

  assign bus.m_rvalid   = vld_q;
  assign bus.m_rdata    = data_q;
  assign bus.m_rresp    = resp_q;
  assign bus.m_rlast    = last_q;
  assign bus.push_ready = !full;
  assign err_orphan     = err_q;

endmodule

// File: tb/tb_dma_rd_resp_router.sv
// tb/tb_dma_rd_resp_router.sv - self-checking bench for dma_rd_resp_router
module tb_dma_rd_resp_router;
  import dma_rd_resp_router_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] outstanding;
  logic       err_orphan;

  int errors = 0;
  int checks = 0;
  int delivered = 0;

  dma_rd_resp_router_if #(.DW(DW)) bus ();

  dma_rd_resp_router #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .outstanding (outstanding),
    .err_orphan  (err_orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: queue of owning channels plus one output slot.
  int          mq[$];
  bit          sv;
  int          sch;
  logic [31:0] sdata;
  logic [1:0]  sresp;
  bit          slast;
  bit          merr;

  initial begin
    bit       acc, orph, was_full, rdy;
    logic [3:0] ev;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
        sv = 0; sch = 0; sdata = '0; sresp = '0; slast = 0; merr = 0;
        chk("rst_m_rvalid", bus.m_rvalid, 4'b0000);
        chk("rst_m_rdata", bus.m_rdata, 32'h0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_push_ready", bus.push_ready, 1'b1);
        chk("rst_err_orphan", err_orphan, 1'b0);
        chk("rst_s_rready", bus.s_rready, 1'b0);
      end else begin
        ev = sv ? (4'b0001 << sch) : 4'b0000;
        chk("m_rvalid", bus.m_rvalid, ev);
        if (sv) begin
          chk("m_rdata", bus.m_rdata, sdata);
          chk("m_rresp", bus.m_rresp, sresp);
          chk("m_rlast", bus.m_rlast, slast);
        end
        chk("outstanding", outstanding, mq.size());
        chk("push_ready", bus.push_ready, mq.size() < DEPTH);
        chk("err_orphan", err_orphan, merr);
        rdy = sv ? bus.m_rready[sch] : 1'b0;
        chk("s_rready", bus.s_rready,
            (mq.size() != 0) ? (!sv || rdy) : (bus.s_rvalid && !bus.push_valid));
        if (sv && rdy) delivered++;

        was_full = (mq.size() == DEPTH);
        acc  = bus.s_rvalid && (mq.size() != 0) && (!sv || rdy);
        orph = bus.s_rvalid && (mq.size() == 0) && !bus.push_valid;
        if (acc) begin
          sv = 1; sch = mq[0];
          sdata = bus.s_rdata; sresp = bus.s_rresp; slast = bus.s_rlast;
          if (bus.s_rlast) void'(mq.pop_front());
        end else if (sv && rdy) begin
          sv = 0;
        end
        if (bus.push_valid && !was_full) mq.push_back(int'(bus.push_ch));
        if (orph) merr = 1;
      end
    end
  end

  task automatic push_tag(input ch_idx_t ch);
    bus.push_valid = 1'b1;
    bus.push_ch    = ch;
    tick();
    bus.push_valid = 1'b0;
  endtask

  task automatic set_beat(input logic [31:0] d, input logic last);
    bus.s_rvalid = 1'b1;
    bus.s_rdata  = d;
    bus.s_rresp  = d[1:0];
    bus.s_rlast  = last;
  endtask

  initial begin
    logic [3:0] b2b_vld [4];
    logic [3:0] drain_vld [3];
    b2b_vld   = '{4'b0010, 4'b0010, 4'b1000, 4'b1000};
    drain_vld = '{4'b0100, 4'b1000, 4'b0100};

    bus.push_valid = 0; bus.push_ch = CH_A;
    bus.s_rvalid = 0; bus.s_rdata = '0; bus.s_rresp = '0; bus.s_rlast = 0;
    bus.m_rready = 4'b1111;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_push_ready", bus.push_ready, 1'b1);
    chk("init_s_rready", bus.s_rready, 1'b0);
    chk("init_outstanding", outstanding, 0);
    rst_n = 1;

    // Single burst on channel C
    push_tag(CH_C);
    chk("sb_outstanding_1", outstanding, 1);
    for (int i = 0; i < 4; i++) begin
      set_beat(32'h11 + i, i == 3);
      tick();
      chk("sb_m_rvalid", bus.m_rvalid, 4'b0100);
      chk("sb_m_rdata", bus.m_rdata, 32'h11 + i);
      chk("sb_outstanding", outstanding, (i == 3) ? 0 : 1);
    end
    bus.s_rvalid = 0; bus.s_rlast = 0;
    tick();
    chk("sb_idle_m_rvalid", bus.m_rvalid, 4'b0000);

    // Back-to-back bursts B then D
    push_tag(CH_B);
    push_tag(CH_D);
    chk("b2b_outstanding", outstanding, 2);
    for (int i = 0; i < 4; i++) begin
      set_beat(32'h31 + i, i[0]);
      tick();
      chk("b2b_m_rvalid", bus.m_rvalid, b2b_vld[i]);
      chk("b2b_m_rdata", bus.m_rdata, 32'h31 + i);
    end
    bus.s_rvalid = 0; bus.s_rlast = 0;
    tick();

    // Backpressure on channel A
    push_tag(CH_A);
    set_beat(32'h21, 1'b0);
    tick();
    chk("bp_first", bus.m_rdata, 32'h21);
    set_beat(32'h22, 1'b0);
    bus.m_rready = 4'b1110;
    #1;
    chk("bp_s_rready_stall", bus.s_rready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_vld", bus.m_rvalid, 4'b0001);
      chk("bp_hold_data", bus.m_rdata, 32'h21);
      chk("bp_hold_s_rready", bus.s_rready, 1'b0);
    end
    bus.m_rready = 4'b1111;
    #1;
    chk("bp_s_rready_release", bus.s_rready, 1'b1);
    tick();
    chk("bp_second", bus.m_rdata, 32'h22);
    set_beat(32'h23, 1'b1);
    tick();
    chk("bp_third", bus.m_rdata, 32'h23);
    bus.s_rvalid = 0; bus.s_rlast = 0;
    tick();

    // Fill the tag FIFO
    push_tag(CH_A);
    push_tag(CH_B);
    push_tag(CH_C);
    push_tag(CH_D);
    chk("full_push_ready", bus.push_ready, 1'b0);
    chk("full_outstanding", outstanding, 4);
    push_tag(CH_B);
    chk("full_ignored_outstanding", outstanding, 4);
    chk("full_ignored_push_ready", bus.push_ready, 1'b0);
    set_beat(32'h50, 1'b1);
    tick();
    bus.s_rvalid = 0;
    chk("retire_push_ready", bus.push_ready, 1'b1);
    chk("retire_outstanding", outstanding, 3);
    chk("retire_m_rvalid", bus.m_rvalid, 4'b0001);
    // Push and pop together
    set_beat(32'h51, 1'b1);
    push_tag(CH_C);
    chk("pushpop_outstanding", outstanding, 3);
    chk("pushpop_m_rvalid", bus.m_rvalid, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      set_beat(32'h52 + i, 1'b1);
      tick();
      chk("drain_m_rvalid", bus.m_rvalid, drain_vld[i]);
    end
    bus.s_rvalid = 0; bus.s_rlast = 0;
    chk("drain_outstanding", outstanding, 0);
    tick();

    // Orphan beat
    chk("pre_orphan_err", err_orphan, 1'b0);
    set_beat(32'h99, 1'b1);
    #1;
    chk("orphan_s_rready", bus.s_rready, 1'b1);
    tick();
    bus.s_rvalid = 0;
    chk("orphan_err", err_orphan, 1'b1);
    chk("orphan_m_rvalid", bus.m_rvalid, 4'b0000);
    tick();
    chk("orphan_err_sticky", err_orphan, 1'b1);

    // Async reset in the middle of a burst
    push_tag(CH_B);
    set_beat(32'h41, 1'b0);
    tick();
    chk("mid_m_rvalid", bus.m_rvalid, 4'b0010);
    set_beat(32'h42, 1'b0);
    #2;
    rst_n = 0;
    bus.s_rvalid = 0;
    #1;
    chk("arst_m_rvalid", bus.m_rvalid, 4'b0000);
    chk("arst_outstanding", outstanding, 0);
    chk("arst_push_ready", bus.push_ready, 1'b1);
    chk("arst_err", err_orphan, 1'b0);
    chk("arst_s_rready", bus.s_rready, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1;
    chk("post_rst_s_rready", bus.s_rready, 1'b0);
    set_beat(32'h42, 1'b1);
    tick();
    bus.s_rvalid = 0; bus.s_rlast = 0;
    chk("post_rst_orphan_err", err_orphan, 1'b1);
    chk("post_rst_m_rvalid", bus.m_rvalid, 4'b0000);
    tick();

    chk("delivered_beats", delivered, 16);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
